// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage and its multiplier.
package ex_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned MUL_STEPS = 32;
    localparam int unsigned CNT_W     = $clog2(MUL_STEPS);
    localparam int unsigned REG_W     = 5;
    localparam int unsigned FUNCT_W   = 10;

    // ALUOp encodings from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // {funct7, funct3} for R-type
    localparam logic [FUNCT_W-1:0] F10_ADD = 10'b0000000_000;
    localparam logic [FUNCT_W-1:0] F10_SUB = 10'b0100000_000;
    localparam logic [FUNCT_W-1:0] F10_AND = 10'b0000000_111;
    localparam logic [FUNCT_W-1:0] F10_XOR = 10'b0000000_100;
    localparam logic [FUNCT_W-1:0] F10_SLL = 10'b0000000_001;
    localparam logic [FUNCT_W-1:0] F10_MUL = 10'b0000001_000;

    // funct3 for I-type ALU
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SRAI = 3'b101;

    typedef enum logic [2:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_XOR,
        ALU_SLL,
        ALU_SRA,
        ALU_MUL
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // EX/MEM pipeline register payload
    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             memto_reg;
        logic             mem_read;
        logic             mem_write;
        logic [XLEN-1:0]  alu_result;
        logic [XLEN-1:0]  rs2_data;
        logic [REG_W-1:0] rd;
    } ex_mem_t;

    // Map ALUOp/funct to an ALU operation; unlisted codes give ALU_NONE
    function automatic alu_op_t decode_alu(input logic [1:0] alu_op,
                                           input logic [FUNCT_W-1:0] funct);
        alu_op_t op;
        op = ALU_NONE;
        case (alu_op)
            ALUOP_ADD: op = ALU_ADD;
            ALUOP_BEQ: op = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    F10_ADD: op = ALU_ADD;
                    F10_SUB: op = ALU_SUB;
                    F10_AND: op = ALU_AND;
                    F10_XOR: op = ALU_XOR;
                    F10_SLL: op = ALU_SLL;
                    F10_MUL: op = ALU_MUL;
                    default: op = ALU_NONE;
                endcase
            end
            ALUOP_ITYPE: begin
                case (funct[2:0])
                    F3_ADDI: op = ALU_ADD;
                    F3_SRAI: op = ALU_SRA;
                    default: op = ALU_NONE;
                endcase
            end
            default: op = ALU_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bundle: ID/EX fields in, stall/branch and EX/MEM fields out.
interface ex_stage_if;
    import ex_pkg::*;

    logic                 valid_i;
    logic [XLEN-1:0]      pc_i;
    logic                 Branch_i;
    logic                 MemRead_i;
    logic                 MemtoReg_i;
    logic                 MemWrite_i;
    logic                 ALUSrc_i;
    logic                 RegWrite_i;
    logic [1:0]           ALUOp_i;
    logic [FUNCT_W-1:0]   funct_i;
    logic [REG_W-1:0]     rd_i;
    logic [XLEN-1:0]      RS1data_i;
    logic [XLEN-1:0]      RS2data_i;
    logic [XLEN-1:0]      imm_i;

    logic                 stall_o;
    logic                 branch_taken_o;
    logic [XLEN-1:0]      branch_target_o;
    logic                 valid_o;
    logic                 RegWrite_o;
    logic                 MemtoReg_o;
    logic                 MemRead_o;
    logic                 MemWrite_o;
    logic [XLEN-1:0]      ALUresult_o;
    logic [XLEN-1:0]      RS2data_o;
    logic [REG_W-1:0]     rd_o;

    modport master (
        output valid_i, pc_i, Branch_i, MemRead_i, MemtoReg_i, MemWrite_i,
               ALUSrc_i, RegWrite_i, ALUOp_i, funct_i, rd_i,
               RS1data_i, RS2data_i, imm_i,
        input  stall_o, branch_taken_o, branch_target_o, valid_o, RegWrite_o,
               MemtoReg_o, MemRead_o, MemWrite_o, ALUresult_o, RS2data_o, rd_o
    );

    modport slave (
        input  valid_i, pc_i, Branch_i, MemRead_i, MemtoReg_i, MemWrite_i,
               ALUSrc_i, RegWrite_i, ALUOp_i, funct_i, rd_i,
               RS1data_i, RS2data_i, imm_i,
        output stall_o, branch_taken_o, branch_target_o, valid_o, RegWrite_o,
               MemtoReg_o, MemRead_o, MemWrite_o, ALUresult_o, RS2data_o, rd_o
    );

endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, low XLEN bits kept.
module mul_iter
    import ex_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            idle_c,
    output logic            busy_c,
    output logic            done_c,
    output logic [XLEN-1:0] product
);

    state_t           state_q, state_n;
    logic [XLEN-1:0]  a_q, a_n;
    logic [XLEN-1:0]  b_q, b_n;
    logic [XLEN-1:0]  acc_q, acc_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    // State and datapath registers; reset aborts any multiply in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
            acc_q   <= acc_n;
            cnt_q   <= cnt_n;
        end
    end

    // Next state and one shift-add step per BUSY cycle
    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        acc_n   = acc_q;
        cnt_n   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_n     = a;
                    b_n     = b;
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (b_q[0]) begin
                    acc_n = acc_q + a_q;
                end
                a_n   = a_q << 1;
                b_n   = b_q >> 1;
                cnt_n = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MUL_STEPS - 1)) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign idle_c  = (state_q == IDLE);
    assign busy_c  = (state_q == BUSY);
    assign done_c  = (state_q == DONE);
    assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU decode, beq resolution, multiplier stall control, EX/MEM register.
module ex_stage
    import ex_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    ex_stage_if.slave  bus
);

    alu_op_t         alu_op_c;
    logic [XLEN-1:0] op_b_c;
    logic [XLEN-1:0] alu_res_c;
    logic            is_mul_c;
    logic            mul_start_c;
    logic            mul_idle_c;
    logic            mul_busy_c;
    logic            mul_done_c;
    logic [XLEN-1:0] mul_product;
    logic            stall_c;
    logic            branch_taken_c;
    ex_mem_t         ex_mem_q, ex_mem_n;

    assign alu_op_c    = decode_alu(bus.ALUOp_i, bus.funct_i);
    assign op_b_c      = bus.ALUSrc_i ? bus.imm_i : bus.RS2data_i;
    assign is_mul_c    = (alu_op_c == ALU_MUL);
    assign mul_start_c = bus.valid_i & is_mul_c;

    mul_iter u_mul (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .start   (mul_start_c),
        .a       (bus.RS1data_i),
        .b       (bus.RS2data_i),
        .idle_c  (mul_idle_c),
        .busy_c  (mul_busy_c),
        .done_c  (mul_done_c),
        .product (mul_product)
    );

    // Single-cycle ALU; mul and unlisted codes give 0 here
    always_comb begin
        alu_res_c = '0;
        case (alu_op_c)
            ALU_ADD: alu_res_c = bus.RS1data_i + op_b_c;
            ALU_SUB: alu_res_c = bus.RS1data_i - op_b_c;
            ALU_AND: alu_res_c = bus.RS1data_i & op_b_c;
            ALU_XOR: alu_res_c = bus.RS1data_i ^ op_b_c;
            ALU_SLL: alu_res_c = bus.RS1data_i << op_b_c[4:0];
            ALU_SRA: alu_res_c = $unsigned($signed(bus.RS1data_i) >>> bus.imm_i[4:0]);
            default: alu_res_c = '0;
        endcase
    end

    // Stall while a mul is being accepted or iterating; quiet during reset
    assign stall_c = rst_i & (mul_busy_c | (mul_idle_c & mul_start_c));

    // beq resolves only when the multiplier is not holding the pipe
    assign branch_taken_c = rst_i & mul_idle_c & bus.valid_i & bus.Branch_i
                          & (bus.RS1data_i == bus.RS2data_i);

    assign bus.stall_o         = stall_c;
    assign bus.branch_taken_o  = branch_taken_c;
    assign bus.branch_target_o = bus.pc_i + {bus.imm_i[XLEN-2:0], 1'b0};

    // EX/MEM next value: bubble on stall or invalid, branch suppresses writes
    always_comb begin
        ex_mem_n = '0;
        if (bus.valid_i && !stall_c) begin
            ex_mem_n.valid      = 1'b1;
            ex_mem_n.reg_write  = bus.RegWrite_i & ~bus.Branch_i;
            ex_mem_n.mem_read   = bus.MemRead_i  & ~bus.Branch_i;
            ex_mem_n.mem_write  = bus.MemWrite_i & ~bus.Branch_i;
            ex_mem_n.memto_reg  = bus.MemtoReg_i;
            ex_mem_n.alu_result = mul_done_c ? mul_product : alu_res_c;
            ex_mem_n.rs2_data   = bus.RS2data_i;
            ex_mem_n.rd         = bus.rd_i;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_n;
        end
    end

    assign bus.valid_o     = ex_mem_q.valid;
    assign bus.RegWrite_o  = ex_mem_q.reg_write;
    assign bus.MemtoReg_o  = ex_mem_q.memto_reg;
    assign bus.MemRead_o   = ex_mem_q.mem_read;
    assign bus.MemWrite_o  = ex_mem_q.mem_write;
    assign bus.ALUresult_o = ex_mem_q.alu_result;
    assign bus.RS2data_o   = ex_mem_q.rs2_data;
    assign bus.rd_o        = ex_mem_q.rd;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, beq, iterative mul, back-to-back mul, reset mid-mul.
module tb_ex_stage;
    import ex_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ex_stage_if bus ();

    ex_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  aluop;
        logic [9:0]  funct;
        logic        src;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11];

    task tick;
        @(posedge clk);
        #1;
    endtask

    task drive(input logic v, input logic [1:0] aluop, input logic [9:0] f,
               input logic src, input logic [31:0] rs1, input logic [31:0] rs2,
               input logic [31:0] imm, input logic [4:0] rd, input logic br,
               input logic regw, input logic memr, input logic memw,
               input logic mtr, input logic [31:0] pc);
        bus.valid_i    = v;
        bus.ALUOp_i    = aluop;
        bus.funct_i    = f;
        bus.ALUSrc_i   = src;
        bus.RS1data_i  = rs1;
        bus.RS2data_i  = rs2;
        bus.imm_i      = imm;
        bus.rd_i       = rd;
        bus.Branch_i   = br;
        bus.RegWrite_i = regw;
        bus.MemRead_i  = memr;
        bus.MemWrite_i = memw;
        bus.MemtoReg_i = mtr;
        bus.pc_i       = pc;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                           output int stalls, output int bubbles_bad,
                           output logic [31:0] res, output logic vld,
                           output logic [4:0] rdo, output logic regw);
        drive(1'b1, 2'b10, 10'h008, 1'b0, a, b, 32'd0, rd, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        stalls      = 0;
        bubbles_bad = 0;
        while (bus.stall_o === 1'b1 && stalls < 100) begin
            stalls++;
            tick();
            if (bus.valid_o !== 1'b0 || bus.RegWrite_o !== 1'b0 ||
                bus.MemRead_o !== 1'b0 || bus.MemWrite_o !== 1'b0)
                bubbles_bad++;
        end
        tick();
        res  = bus.ALUresult_o;
        vld  = bus.valid_o;
        rdo  = bus.rd_o;
        regw = bus.RegWrite_o;
    endtask

    task test_reset;
        rst = 1'b0;
        drive(1'b1, 2'b10, 10'h008, 1'b0, 32'd3, 32'd3, 32'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
        tick();
        tick();
        n_checks++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.stall_o); end
        n_checks++; if (bus.branch_taken_o !== 1'b0) begin n_fail++; $display("FAIL reset_branch_taken: got %b expected 0", bus.branch_taken_o); end
        n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.valid_o); end
        n_checks++; if (bus.RegWrite_o !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b expected 0", bus.RegWrite_o); end
        n_checks++; if (bus.MemRead_o !== 1'b0) begin n_fail++; $display("FAIL reset_memread: got %b expected 0", bus.MemRead_o); end
        n_checks++; if (bus.MemWrite_o !== 1'b0) begin n_fail++; $display("FAIL reset_memwrite: got %b expected 0", bus.MemWrite_o); end
        n_checks++; if (bus.MemtoReg_o !== 1'b0) begin n_fail++; $display("FAIL reset_memtoreg: got %b expected 0", bus.MemtoReg_o); end
        n_checks++; if (bus.ALUresult_o !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", bus.ALUresult_o); end
        n_checks++; if (bus.RS2data_o !== 32'h0) begin n_fail++; $display("FAIL reset_rs2data: got %h expected 00000000", bus.RS2data_o); end
        n_checks++; if (bus.rd_o !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d expected 0", bus.rd_o); end
        drive(1'b0, 2'b00, 10'h000, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
    endtask

    task test_alu;
        vecs[0]  = '{2'b10, 10'h000, 1'b0, 32'd5,         32'd7,         32'd0,         32'd12};
        vecs[1]  = '{2'b10, 10'h100, 1'b0, 32'd5,         32'd7,         32'd0,         32'hFFFF_FFFE};
        vecs[2]  = '{2'b10, 10'h007, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0,         32'h00F0_000F};
        vecs[3]  = '{2'b10, 10'h004, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0,         32'hF0F0_0F0F};
        vecs[4]  = '{2'b10, 10'h001, 1'b0, 32'd1,         32'h0000_0023, 32'd0,         32'd8};
        vecs[5]  = '{2'b11, 10'h000, 1'b1, 32'h10,        32'h0000_AAAA, 32'hFFFF_FFFF, 32'h0000_000F};
        vecs[6]  = '{2'b11, 10'h105, 1'b1, 32'hFFFF_FF00, 32'h55,        32'd4,         32'hFFFF_FFF0};
        vecs[7]  = '{2'b10, 10'h002, 1'b0, 32'd9,         32'd3,         32'd0,         32'd0};
        vecs[8]  = '{2'b00, 10'h000, 1'b1, 32'h100,       32'hDEAD_BEEF, 32'hFFFF_FFFC, 32'h0000_00FC};
        vecs[9]  = '{2'b11, 10'h002, 1'b1, 32'd7,         32'd0,         32'd5,         32'd0};
        vecs[10] = '{2'b10, 10'h000, 1'b1, 32'd5,         32'd100,       32'd1,         32'd6};
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vecs[i].aluop, vecs[i].funct, vecs[i].src, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].imm, 5'(i + 1), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            #1;
            n_checks++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL alu_vec%0d_stall: got %b expected 0", i, bus.stall_o); end
            tick();
            n_checks++; if (bus.ALUresult_o !== vecs[i].exp) begin n_fail++; $display("FAIL alu_vec%0d_result: got %h expected %h", i, bus.ALUresult_o, vecs[i].exp); end
            n_checks++; if (bus.RS2data_o !== vecs[i].rs2) begin n_fail++; $display("FAIL alu_vec%0d_rs2data: got %h expected %h", i, bus.RS2data_o, vecs[i].rs2); end
            n_checks++; if (bus.rd_o !== 5'(i + 1)) begin n_fail++; $display("FAIL alu_vec%0d_rd: got %0d expected %0d", i, bus.rd_o, i + 1); end
            n_checks++; if (bus.valid_o !== 1'b1 || bus.RegWrite_o !== 1'b1) begin n_fail++; $display("FAIL alu_vec%0d_ctrl: got valid=%b regwrite=%b expected 1/1", i, bus.valid_o, bus.RegWrite_o); end
        end
    endtask

    task test_beq;
        drive(1'b1, 2'b01, 10'h000, 1'b0, 32'd3, 32'd3, 32'd8, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40);
        #1;
        n_checks++; if (bus.branch_taken_o !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %b expected 1", bus.branch_taken_o); end
        n_checks++; if (bus.branch_target_o !== 32'h50) begin n_fail++; $display("FAIL beq_target: got %h expected 00000050", bus.branch_target_o); end
        n_checks++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL beq_stall: got %b expected 0", bus.stall_o); end
        tick();
        n_checks++; if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL beq_valid: got %b expected 1", bus.valid_o); end
        n_checks++; if (bus.RegWrite_o !== 1'b0 || bus.MemWrite_o !== 1'b0 || bus.MemRead_o !== 1'b0) begin
            n_fail++; $display("FAIL beq_bubble: got regw=%b memw=%b memr=%b expected 0/0/0", bus.RegWrite_o, bus.MemWrite_o, bus.MemRead_o);
        end
        drive(1'b1, 2'b01, 10'h000, 1'b0, 32'd3, 32'd4, 32'hFFFF_FFF8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40);
        #1;
        n_checks++; if (bus.branch_taken_o !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken: got %b expected 0", bus.branch_taken_o); end
        n_checks++; if (bus.branch_target_o !== 32'h30) begin n_fail++; $display("FAIL beq_neg_target: got %h expected 00000030", bus.branch_target_o); end
        drive(1'b0, 2'b01, 10'h000, 1'b0, 32'd3, 32'd3, 32'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40);
        #1;
        n_checks++; if (bus.branch_taken_o !== 1'b0) begin n_fail++; $display("FAIL beq_invalid: got %b expected 0", bus.branch_taken_o); end
        tick();
        n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL invalid_bubble: got %b expected 0", bus.valid_o); end
    endtask

    task automatic test_mul;
        int stalls, bad;
        logic [31:0] res;
        logic vld, regw;
        logic [4:0] rdo;
        run_mul(32'h0001_0003, 32'h0000_0005, 5'd7, stalls, bad, res, vld, rdo, regw);
        n_checks++; if (stalls != 33) begin n_fail++; $display("FAIL mul_stall_cycles: got %0d expected 33", stalls); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mul_bubbles: got %0d non-bubble cycles expected 0", bad); end
        n_checks++; if (res !== 32'h0005_000F) begin n_fail++; $display("FAIL mul_result: got %h expected 0005000f", res); end
        n_checks++; if (vld !== 1'b1 || regw !== 1'b1 || rdo !== 5'd7) begin
            n_fail++; $display("FAIL mul_ctrl: got valid=%b regw=%b rd=%0d expected 1/1/7", vld, regw, rdo);
        end
    endtask

    task automatic test_back_to_back;
        int stalls, bad;
        logic [31:0] res;
        logic vld, regw;
        logic [4:0] rdo;
        run_mul(32'hFFFF_FFFF, 32'h0000_0002, 5'd3, stalls, bad, res, vld, rdo, regw);
        n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mul_ovf_result: got %h expected fffffffe", res); end
        n_checks++; if (stalls != 33 || bad != 0 || vld !== 1'b1 || rdo !== 5'd3) begin
            n_fail++; $display("FAIL mul_ovf_timing: got stalls=%0d bad=%0d valid=%b rd=%0d expected 33/0/1/3", stalls, bad, vld, rdo);
        end
        run_mul(32'h0000_1234, 32'h0000_0010, 5'd4, stalls, bad, res, vld, rdo, regw);
        n_checks++; if (res !== 32'h0001_2340) begin n_fail++; $display("FAIL mul_b2b_result: got %h expected 00012340", res); end
        n_checks++; if (stalls != 33 || bad != 0 || vld !== 1'b1 || rdo !== 5'd4) begin
            n_fail++; $display("FAIL mul_b2b_timing: got stalls=%0d bad=%0d valid=%b rd=%0d expected 33/0/1/4", stalls, bad, vld, rdo);
        end
        drive(1'b0, 2'b00, 10'h000, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        n_checks++; if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL mul_no_duplicate: got valid=%b expected 0", bus.valid_o); end
    endtask

    task test_reset_mid_mul;
        drive(1'b1, 2'b10, 10'h008, 1'b0, 32'h0000_1111, 32'h0000_0003, 32'd0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        n_checks++; if (bus.stall_o !== 1'b1) begin n_fail++; $display("FAIL rmm_start_stall: got %b expected 1", bus.stall_o); end
        for (int k = 0; k < 11; k++) tick();
        rst = 1'b0;
        #1;
        n_checks++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL rmm_stall: got %b expected 0", bus.stall_o); end
        tick();
        n_checks++; if (bus.valid_o !== 1'b0 || bus.RegWrite_o !== 1'b0 || bus.ALUresult_o !== 32'h0 || bus.rd_o !== 5'd0) begin
            n_fail++; $display("FAIL rmm_outputs: got valid=%b regw=%b result=%h rd=%0d expected all 0", bus.valid_o, bus.RegWrite_o, bus.ALUresult_o, bus.rd_o);
        end
        rst = 1'b1;
        drive(1'b1, 2'b10, 10'h000, 1'b0, 32'd2, 32'd3, 32'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        n_checks++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL rmm_add_stall: got %b expected 0", bus.stall_o); end
        tick();
        n_checks++; if (bus.ALUresult_o !== 32'd5 || bus.valid_o !== 1'b1 || bus.rd_o !== 5'd5) begin
            n_fail++; $display("FAIL rmm_add_result: got result=%h valid=%b rd=%0d expected 00000005/1/5", bus.ALUresult_o, bus.valid_o, bus.rd_o);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_beq();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
